// File: rtl/regfile_dump.sv
// Register-file read-back engine: sweeps rID over every register, streams each
// sampled value on a valid/ready port, then sends a wrapping checksum word.
module regfile_dump #(
  parameter int NUM_REGS = 8,
  parameter int ID_W     = 4,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ID_W-1:0]   rID,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ID_W-1:0]   out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REGS - 1);
  localparam logic [2:0]      LAT      = 3'(READ_LAT);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SEND, S_CSUM, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   idx_q, idx_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ID_W-1:0]   oidx_q, oidx_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ovalid_q, ovalid_d;
  logic              olast_q, olast_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic [DATA_W-1:0] csum_next;

  assign accept    = ovalid_q & out_ready;
  assign csum_next = csum_q + odata_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rid_d    = rid_q;
    oidx_d   = oidx_q;
    csum_d   = csum_q;
    odata_d  = odata_q;
    cnt_d    = cnt_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          busy_d  = 1'b1;
          idx_d   = '0;
          rid_d   = '0;
          csum_d  = '0;
        end
      end
      S_ISSUE: begin
        // rID was already driven on entry, so a zero-latency port has rdata now
        cnt_d = LAT;
        if (LAT == 3'd0) begin
          odata_d  = rdata;
          oidx_d   = idx_q;
          ovalid_d = 1'b1;
          state_d  = S_SEND;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          odata_d  = rdata;
          oidx_d   = idx_q;
          ovalid_d = 1'b1;
          state_d  = S_SEND;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_SEND: begin
        if (accept) begin
          csum_d   = csum_next;
          ovalid_d = 1'b0;
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + ID_W'(1);
            rid_d   = idx_q + ID_W'(1);
            state_d = S_ISSUE;
          end else begin
            odata_d  = csum_next;
            oidx_d   = '1;
            olast_d  = 1'b1;
            ovalid_d = 1'b1;
            state_d  = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          ovalid_d = 1'b0;
          olast_d  = 1'b0;
          state_d  = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        olast_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rid_q    <= '0;
      oidx_q   <= '0;
      csum_q   <= '0;
      odata_q  <= '0;
      cnt_q    <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rid_q    <= rid_d;
      oidx_q   <= oidx_d;
      csum_q   <= csum_d;
      odata_q  <= odata_d;
      cnt_q    <= cnt_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rID       = rid_q;
  assign out_valid = ovalid_q;
  assign out_data  = odata_q;
  assign out_idx   = oidx_q;
  assign out_last  = olast_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: an 8-register/1-latency instance and a
// 1-register/0-latency instance, each fed by a small register-file model.
module tb_regfile_dump;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  // instance A: NUM_REGS=8, READ_LAT=1
  logic        start_a, ov_a, or_a, ol_a, busy_a, done_a;
  logic [3:0]  rid_a, oi_a, rid_a_d1;
  logic [31:0] rdata_a, od_a;
  logic [31:0] regs_a [16];
  always @(posedge clock) rid_a_d1 <= rid_a;
  assign rdata_a = regs_a[rid_a_d1];

  // instance B: NUM_REGS=1, READ_LAT=0 (combinational read port)
  logic        start_b, ov_b, or_b, ol_b, busy_b, done_b;
  logic [3:0]  rid_b, oi_b;
  logic [31:0] rdata_b, od_b;
  logic [31:0] regs_b [16];
  assign rdata_b = regs_b[rid_b];

  regfile_dump #(.NUM_REGS(8), .ID_W(4), .DATA_W(32), .READ_LAT(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .rID(rid_a), .rdata(rdata_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .out_idx(oi_a),
    .out_last(ol_a), .busy(busy_a), .done(done_a));

  regfile_dump #(.NUM_REGS(1), .ID_W(4), .DATA_W(32), .READ_LAT(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .rID(rid_b), .rdata(rdata_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .out_idx(oi_b),
    .out_last(ol_b), .busy(busy_b), .done(done_b));

  // accepted-word logs, sampled mid-cycle
  logic [31:0] qd_a[$];
  logic [3:0]  qi_a[$];
  logic        ql_a[$];
  logic [31:0] qd_b[$];
  logic [3:0]  qi_b[$];
  logic        ql_b[$];
  int done_cnt_a = 0, done_cyc_a = 0, done_cnt_b = 0, done_cyc_b = 0;
  int start_cyc_a = 0, start_cyc_b = 0;

  always @(negedge clock) begin
    if (ov_a && or_a) begin qd_a.push_back(od_a); qi_a.push_back(oi_a); ql_a.push_back(ol_a); end
    if (ov_b && or_b) begin qd_b.push_back(od_b); qi_b.push_back(oi_b); ql_b.push_back(ol_b); end
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic clear_a();
    qd_a.delete(); qi_a.delete(); ql_a.delete();
  endtask

  task automatic pulse_a();
    start_a = 1'b1; start_cyc_a = cyc + 1; tick(1); start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int target, input int limit);
    for (int i = 0; i < limit && done_cnt_a < target; i++) tick(1);
    chk(tag, 32'(done_cnt_a), 32'(target));
  endtask

  task automatic check_sweep_a(input string tag, input logic [31:0] csum);
    chk({tag, "_nwords"}, 32'(qd_a.size()), 32'd9);
    if (qd_a.size() == 9) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("%s_data%0d", tag, i), qd_a[i], regs_a[i]);
        chk($sformatf("%s_idx%0d", tag, i), 32'(qi_a[i]), 32'(i));
        chk($sformatf("%s_last%0d", tag, i), 32'(ql_a[i]), 32'd0);
      end
      chk({tag, "_csum_idx"}, 32'(qi_a[8]), 32'hF);
      chk({tag, "_csum"}, qd_a[8], csum);
      chk({tag, "_csum_last"}, 32'(ql_a[8]), 32'd1);
    end
  endtask

  initial begin
    start_a = 1'b0; or_a = 1'b1;
    start_b = 1'b0; or_b = 1'b1;
    for (int i = 0; i < 16; i++) begin regs_a[i] = 32'h80 + 32'(i); regs_b[i] = 32'h0; end
    regs_b[0] = 32'h5;

    // reset state
    tick(2);
    chk("rst_valid", 32'(ov_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_rid", 32'(rid_a), 32'd0);
    chk("rst_last", 32'(ol_a), 32'd0);
    chk("rst_data", od_a, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // basic sweep
    clear_a(); pulse_a();
    chk("basic_busy", 32'(busy_a), 32'd1);
    wait_done_a("basic_done", 1, 200);
    chk("basic_latency", 32'(done_cyc_a - start_cyc_a), 32'd34);
    check_sweep_a("basic", 32'h41C);
    tick(1);
    chk("basic_idle", 32'(busy_a), 32'd0);

    // backpressure while idx 3 is presented
    clear_a(); pulse_a();
    for (int i = 0; i < 100 && !(ov_a && oi_a == 4'd3); i++) tick(1);
    or_a = 1'b0;
    chk("bp_seen_idx3", 32'(oi_a), 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk($sformatf("bp_data_c%0d", i), od_a, 32'h83);
      chk($sformatf("bp_rid_c%0d", i), 32'(rid_a), 32'd3);
      chk($sformatf("bp_valid_c%0d", i), 32'(ov_a), 32'd1);
    end
    or_a = 1'b1;
    wait_done_a("bp_done", 2, 200);
    check_sweep_a("bp", 32'h41C);

    // checksum wrap
    for (int i = 0; i < 8; i++) regs_a[i] = 32'hFFFF_FFFF;
    clear_a(); tick(1); pulse_a();
    wait_done_a("wrap_done", 3, 200);
    check_sweep_a("wrap", 32'hFFFF_FFF8);

    // start during sweep is ignored
    for (int i = 0; i < 8; i++) regs_a[i] = 32'h80 + 32'(i);
    clear_a(); tick(1); pulse_a();
    tick(10);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    wait_done_a("ign_done", 4, 200);
    tick(20);
    chk("ign_one_dump", 32'(done_cnt_a), 32'd4);
    chk("ign_nwords", 32'(qd_a.size()), 32'd9);
    chk("ign_idle", 32'(busy_a), 32'd0);

    // start held high: next dump only after done
    clear_a(); start_a = 1'b1;
    wait_done_a("held_done1", 5, 200);
    chk("held_nwords1", 32'(qd_a.size()), 32'd9);
    chk("held_restart", 32'(busy_a), 32'd1);
    start_a = 1'b0;
    wait_done_a("held_done2", 6, 200);
    chk("held_nwords2", 32'(qd_a.size()), 32'd18);
    if (qd_a.size() == 18) chk("held_csum2", qd_a[17], 32'h41C);

    // async reset mid-SEND
    clear_a(); tick(1); pulse_a();
    for (int i = 0; i < 100 && !(ov_a && oi_a == 4'd3); i++) tick(1);
    or_a = 1'b0;
    tick(1);
    chk("mid_valid_pre", 32'(ov_a), 32'd1);
    chk("mid_rid_pre", 32'(rid_a), 32'd3);
    reset_n = 1'b0; #1;
    chk("mid_valid", 32'(ov_a), 32'd0);
    chk("mid_busy", 32'(busy_a), 32'd0);
    chk("mid_done", 32'(done_a), 32'd0);
    chk("mid_rid", 32'(rid_a), 32'd0);
    chk("mid_data", od_a, 32'd0);
    #1 reset_n = 1'b1; or_a = 1'b1;
    tick(2);
    clear_a(); pulse_a();
    wait_done_a("post_rst_done", 7, 200);
    chk("post_rst_latency", 32'(done_cyc_a - start_cyc_a), 32'd34);
    check_sweep_a("post_rst", 32'h41C);

    // zero-latency, single register
    start_b = 1'b1; start_cyc_b = cyc + 1; tick(1); start_b = 1'b0;
    for (int i = 0; i < 50 && done_cnt_b < 1; i++) tick(1);
    chk("lat0_done", 32'(done_cnt_b), 32'd1);
    chk("lat0_latency", 32'(done_cyc_b - start_cyc_b), 32'd4);
    chk("lat0_nwords", 32'(qd_b.size()), 32'd2);
    if (qd_b.size() == 2) begin
      chk("lat0_idx0", 32'(qi_b[0]), 32'd0);
      chk("lat0_data0", qd_b[0], 32'h5);
      chk("lat0_last0", 32'(ql_b[0]), 32'd0);
      chk("lat0_csum_idx", 32'(qi_b[1]), 32'hF);
      chk("lat0_csum", qd_b[1], 32'h5);
      chk("lat0_csum_last", 32'(ql_b[1]), 32'd1);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
